// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the mem_io bus arbiter.
package mem_bus_pkg;

    localparam int unsigned AW_DEF  = 16;
    localparam int unsigned DW_DEF  = 16;
    localparam int unsigned BURST_W = 4;

    // Base of the memory-mapped I/O window, used by benches.
    localparam logic [15:0] MEM_IO_BASE = 16'hF000;

    typedef enum logic {
        MID_M0 = 1'b0,
        MID_M1 = 1'b1
    } master_id_e;

    // Read-return tag: valid marks a read, id names the issuing master.
    typedef struct packed {
        logic       valid;
        master_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports plus the mem_io command/return port.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);

    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_din;
    logic          m0_we;
    logic          m0_gnt;
    logic [DW-1:0] m0_rdata;
    logic          m0_rvalid;

    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_din;
    logic          m1_we;
    logic          m1_gnt;
    logic [DW-1:0] m1_rdata;
    logic          m1_rvalid;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    // Arbiter side
    modport arb (
        input  m0_req, m0_addr, m0_din, m0_we,
        input  m1_req, m1_addr, m1_din, m1_we,
        input  mem_dout,
        output m0_gnt, m0_rdata, m0_rvalid,
        output m1_gnt, m1_rdata, m1_rvalid,
        output mem_addr, mem_din, mem_we
    );

    // Requester / memory side
    modport env (
        output m0_req, m0_addr, m0_din, m0_we,
        output m1_req, m1_addr, m1_din, m1_we,
        output mem_dout,
        input  m0_gnt, m0_rdata, m0_rvalid,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  mem_addr, mem_din, mem_we
    );

endinterface

// File: rtl/mem_rd_tag_pipe.sv
// Shift register of read tags; the emerging tag lines up with mem_dout.
module mem_rd_tag_pipe
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] stage_q;
    rd_tag_t [DEPTH-1:0] stage_d;

    // Shift one stage per cycle; a new tag enters every cycle (writes push valid=0)
    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], tag_in};
    end

    // Tag storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the mem_io port between M0 (CPU)
// and M1 (LFSR/serial engine), with tagged read-data return.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_bus_arbiter_if.arb bus
);

    localparam int unsigned         TAG_DEPTH = READ_LATENCY + 1;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_SAT = {BURST_W{1'b1}};

    master_id_e         owner_q, owner_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_din_q, mem_din_d;
    logic               mem_we_q, mem_we_d;
    logic [DW-1:0]      m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]      m1_rdata_q, m1_rdata_d;
    logic               m0_rvalid_q, m0_rvalid_d;
    logic               m1_rvalid_q, m1_rvalid_d;

    logic       gnt0_c, gnt1_c, accept_c;
    master_id_e win_c;
    rd_tag_t    push_tag_c;
    rd_tag_t    pop_tag;

    // Grant: lone requester wins; under contention the owner keeps the bus until its burst is spent
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            if (burst_q < BURST_MAX) begin
                gnt0_c = (owner_q == MID_M0);
                gnt1_c = (owner_q == MID_M1);
            end else begin
                gnt0_c = (owner_q == MID_M1);
                gnt1_c = (owner_q == MID_M0);
            end
        end else begin
            gnt0_c = bus.m0_req;
            gnt1_c = bus.m1_req;
        end
    end

    assign accept_c = gnt0_c | gnt1_c;
    assign win_c    = gnt1_c ? MID_M1 : MID_M0;

    // Next state: ownership/burst tracking, command issue and read return
    always_comb begin
        owner_d     = owner_q;
        burst_d     = burst_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        push_tag_c  = '0;

        if (accept_c) begin
            if (win_c == owner_q) begin
                if (burst_q != BURST_SAT) begin
                    burst_d = burst_q + BURST_W'(1);
                end
            end else begin
                owner_d = win_c;
                burst_d = BURST_W'(1);
            end
            mem_addr_d       = gnt1_c ? bus.m1_addr : bus.m0_addr;
            mem_din_d        = gnt1_c ? bus.m1_din  : bus.m0_din;
            mem_we_d         = gnt1_c ? bus.m1_we   : bus.m0_we;
            push_tag_c.valid = !mem_we_d;
            push_tag_c.id    = win_c;
        end

        m0_rvalid_d = pop_tag.valid && (pop_tag.id == MID_M0);
        m1_rvalid_d = pop_tag.valid && (pop_tag.id == MID_M1);
        m0_rdata_d  = m0_rvalid_d ? bus.mem_dout : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? bus.mem_dout : m1_rdata_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= MID_M0;
            burst_q     <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    mem_rd_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (push_tag_c),
        .tag_out (pop_tag)
    );

    assign bus.m0_gnt    = gnt0_c;
    assign bus.m1_gnt    = gnt1_c;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against
// a transaction-level model (grant streaks, memory contents, return queue).
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int RL  = 1;
    localparam int RL3 = 3;
    localparam int MB  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clear;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(16), .DW(16)) bus  ();
    mem_bus_arbiter_if #(.AW(16), .DW(16)) bus3 ();

    mem_bus_arbiter #(.AW(16), .DW(16), .READ_LATENCY(RL), .MAX_BURST(MB)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );

    mem_bus_arbiter #(.AW(16), .DW(16), .READ_LATENCY(RL3), .MAX_BURST(MB)) u_dut3 (
        .clk (clk), .rst_n (rst_n), .bus (bus3)
    );

    // Power-on contents of the emulated mem_io
    function automatic logic [15:0] init_val(input logic [7:0] a);
        return {a ^ 8'h5A, 8'hC3 ^ {a[3:0], a[7:4]}};
    endfunction

    // mem_io emulation: synchronous memory with RL / RL3 cycles of read latency
    logic [15:0] mem [256];
    logic [15:0] rd1 [RL];
    logic [15:0] rd3 [RL3];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_din;
        end
        rd1[0] <= mem[bus.mem_addr[7:0]];
        for (int i = 1; i < RL; i++) rd1[i] <= rd1[i-1];
        rd3[0] <= init_val(bus3.mem_addr[7:0]);
        for (int i = 1; i < RL3; i++) rd3[i] <= rd3[i-1];
    end
    assign bus.mem_dout  = rd1[RL-1];
    assign bus3.mem_dout = rd3[RL3-1];

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m0_addr = '0; bus.m0_din = '0; bus.m0_we = 0;
        bus.m1_req = 0; bus.m1_addr = '0; bus.m1_din = '0; bus.m1_we = 0;
        bus3.m0_req = 0; bus3.m0_addr = '0; bus3.m0_din = '0; bus3.m0_we = 0;
        bus3.m1_req = 0; bus3.m1_addr = '0; bus3.m1_din = '0; bus3.m1_we = 0;
    endtask

    task automatic set_m0(input logic req, input logic [15:0] a, input logic [15:0] d, input logic we);
        bus.m0_req = req; bus.m0_addr = a; bus.m0_din = d; bus.m0_we = we;
    endtask

    task automatic set_m1(input logic req, input logic [15:0] a, input logic [15:0] d, input logic we);
        bus.m1_req = req; bus.m1_addr = a; bus.m1_din = d; bus.m1_we = we;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 0;
        mem_clear = 1;
        repeat (2) @(negedge clk);
        mem_clear = 0;
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_clear = 1;
        rst_n = 1;
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        mem_clear = 0;
        #1;
        total++; if (bus.mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0000", bus.mem_addr); end
        total++; if (bus.mem_din !== 16'h0) begin bad++; $display("FAIL reset_mem_din got=%h exp=0000", bus.mem_din); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
        total++; if ({bus.m0_rvalid, bus.m1_rvalid, bus3.m1_rvalid} !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", {bus.m0_rvalid, bus.m1_rvalid, bus3.m1_rvalid}); end
        total++; if ({bus.m0_rdata, bus.m1_rdata} !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", {bus.m0_rdata, bus.m1_rdata}); end
        total++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin bad++; $display("FAIL reset_idle_gnt got=%b exp=00", {bus.m0_gnt, bus.m1_gnt}); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        set_m0(1, 16'hF060, 16'h0, 0);
        set_m1(1, 16'hF061, 16'h0, 0);
        #1;
        total++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin bad++; $display("FAIL reset_first_contention got=%b exp=10", {bus.m0_gnt, bus.m1_gnt}); end
        idle_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        set_m0(1, 16'hF060, 16'h1234, 0);
        #1;
        total++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin bad++; $display("FAIL single_gnt got=%b exp=10", {bus.m0_gnt, bus.m1_gnt}); end
        @(negedge clk);
        set_m0(0, 16'h0, 16'h0, 0);
        total++; if ({bus.mem_addr, bus.mem_we} !== {16'hF060, 1'b0}) begin bad++; $display("FAIL single_issue got=%h/%b exp=f060/0", bus.mem_addr, bus.mem_we); end
        for (int j = 2; j <= 4; j++) begin
            @(negedge clk);
            total++;
            if ({bus.m0_rvalid, bus.m1_rvalid} !== ((j == 3) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL single_rvalid cyc=%0d got=%b exp=%b", j, {bus.m0_rvalid, bus.m1_rvalid}, (j == 3) ? 2'b10 : 2'b00);
            end
            if (j == 3) begin
                total++; if (bus.m0_rdata !== init_val(8'h60)) begin bad++; $display("FAIL single_rdata got=%h exp=%h", bus.m0_rdata, init_val(8'h60)); end
            end
        end
    endtask

    task automatic test_m1_writes();
        logic [15:0] ea;
        do_reset();
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            if (j >= 1) begin
                ea = (j <= 3) ? 16'(16'hF070 + j - 1) : 16'hF072;
                total++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_din} !== {(j <= 3), ea, 16'hFFFF}) begin
                    bad++; $display("FAIL wr_issue cyc=%0d got=%b/%h/%h exp=%b/%h/ffff", j, bus.mem_we, bus.mem_addr, bus.mem_din, (j <= 3), ea);
                end
            end
            if (j < 3) begin
                set_m1(1, 16'(16'hF070 + j), 16'hFFFF, 1);
                #1;
                total++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin bad++; $display("FAIL wr_gnt cyc=%0d got=%b exp=01", j, {bus.m0_gnt, bus.m1_gnt}); end
            end else begin
                set_m1(0, 16'hF072, 16'hFFFF, 0);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_m0(1, 16'hF060, 16'h0, 0);
            set_m1(1, 16'hF061, 16'h0, 0);
            #1;
            eg = ((i / MB) % 2 == 0) ? 2'b10 : 2'b01;
            total++; if ({bus.m0_gnt, bus.m1_gnt} !== eg) begin bad++; $display("FAIL burst_seq i=%0d got=%b exp=%b", i, {bus.m0_gnt, bus.m1_gnt}, eg); end
        end
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_interleaved();
        logic [1:0] ev;
        do_reset();
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            ev = (j == 3 || j == 5) ? 2'b10 : (j == 4) ? 2'b01 : 2'b00;
            total++; if ({bus.m0_rvalid, bus.m1_rvalid} !== ev) begin bad++; $display("FAIL intlv_rvalid cyc=%0d got=%b exp=%b", j, {bus.m0_rvalid, bus.m1_rvalid}, ev); end
            if (j == 4) begin
                total++;
                if ({bus.m0_rdata, bus.m1_rdata} !== {init_val(8'h60), init_val(8'h63)}) begin
                    bad++; $display("FAIL intlv_rdata got=%h/%h exp=%h/%h", bus.m0_rdata, bus.m1_rdata, init_val(8'h60), init_val(8'h63));
                end
            end
            idle_inputs();
            if (j == 0 || j == 2) set_m0(1, 16'hF060, 16'h0, 0);
            if (j == 1) set_m1(1, 16'hF063, 16'h0, 0);
            #1;
            if (j < 3) begin
                ev = (j == 1) ? 2'b01 : 2'b10;
                total++; if ({bus.m0_gnt, bus.m1_gnt} !== ev) begin bad++; $display("FAIL intlv_gnt cyc=%0d got=%b exp=%b", j, {bus.m0_gnt, bus.m1_gnt}, ev); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        @(negedge clk);
        set_m1(1, 16'hF061, 16'h0, 0);
        @(negedge clk);
        set_m1(1, 16'hF072, 16'hBEEF, 1);
        @(negedge clk);
        idle_inputs();
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL midrst_pre_we got=%b exp=1", bus.mem_we); end
        #2 rst_n = 0;
        #1;
        total++;
        if ({bus.mem_we, bus.mem_addr, bus.m0_rvalid, bus.m1_rvalid} !== {1'b0, 16'h0, 2'b00}) begin
            bad++; $display("FAIL midrst_async got=%b/%h/%b exp=0/0000/00", bus.mem_we, bus.mem_addr, {bus.m0_rvalid, bus.m1_rvalid});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            total++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin bad++; $display("FAIL midrst_late_rvalid cyc=%0d got=%b exp=00", j, {bus.m0_rvalid, bus.m1_rvalid}); end
        end
        set_m0(1, 16'hF060, 16'h0, 0);
        set_m1(1, 16'hF061, 16'h0, 0);
        #1;
        total++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin bad++; $display("FAIL midrst_owner got=%b exp=10", {bus.m0_gnt, bus.m1_gnt}); end
        idle_inputs();
    endtask

    task automatic test_latency3();
        do_reset();
        @(negedge clk);
        bus3.m1_req = 1; bus3.m1_addr = 16'hF062; bus3.m1_we = 0;
        #1;
        total++; if ({bus3.m0_gnt, bus3.m1_gnt} !== 2'b01) begin bad++; $display("FAIL lat3_gnt got=%b exp=01", {bus3.m0_gnt, bus3.m1_gnt}); end
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            bus3.m1_req = 0;
            total++;
            if ({bus3.m0_rvalid, bus3.m1_rvalid} !== ((j == RL3 + 2) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL lat3_rvalid cyc=%0d got=%b exp=%b", j, {bus3.m0_rvalid, bus3.m1_rvalid}, (j == RL3 + 2) ? 2'b01 : 2'b00);
            end
            if (j == RL3 + 2) begin
                total++; if (bus3.m1_rdata !== init_val(8'h62)) begin bad++; $display("FAIL lat3_rdata got=%h exp=%h", bus3.m1_rdata, init_val(8'h62)); end
            end
        end
    endtask

    typedef struct {
        int          due;
        logic        id;
        logic [15:0] data;
    } ret_t;

    task automatic test_random(input int n);
        logic [15:0] refmem [256];
        ret_t        q[$];
        ret_t        r;
        logic [15:0] exp_addr, exp_din, r0, r1;
        logic        exp_we, last, w, ev0, ev1, eg0, eg1, we;
        int          run;
        do_reset();
        for (int i = 0; i < 256; i++) refmem[i] = init_val(8'(i));
        exp_addr = '0; exp_din = '0; exp_we = 0; r0 = '0; r1 = '0;
        last = 0; run = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            total++;
            if ({bus.mem_we, bus.mem_addr, bus.mem_din} !== {exp_we, exp_addr, exp_din}) begin
                bad++; $display("FAIL rnd_issue c=%0d got=%b/%h/%h exp=%b/%h/%h", c, bus.mem_we, bus.mem_addr, bus.mem_din, exp_we, exp_addr, exp_din);
            end
            ev0 = 0; ev1 = 0;
            if (q.size() > 0 && q[0].due == c) begin
                r = q.pop_front();
                if (r.id) begin ev1 = 1; r1 = r.data; end
                else begin ev0 = 1; r0 = r.data; end
            end
            total++; if ({bus.m0_rvalid, bus.m1_rvalid} !== {ev0, ev1}) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, {bus.m0_rvalid, bus.m1_rvalid}, {ev0, ev1}); end
            total++; if ({bus.m0_rdata, bus.m1_rdata} !== {r0, r1}) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, bus.m0_rdata, bus.m1_rdata, r0, r1); end

            if (c < n - 8) begin
                we = 1'($urandom_range(1));
                set_m0($urandom_range(3) != 0,
                       we ? 16'(16'hF070 + $urandom_range(3)) : ($urandom_range(1) ? 16'(16'hF060 + $urandom_range(15)) : 16'(16'hF070 + $urandom_range(3))),
                       16'($urandom), we);
                we = 1'($urandom_range(1));
                set_m1($urandom_range(3) != 0,
                       we ? 16'(16'hF070 + $urandom_range(3)) : ($urandom_range(1) ? 16'(16'hF060 + $urandom_range(15)) : 16'(16'hF070 + $urandom_range(3))),
                       16'($urandom), we);
            end else begin
                idle_inputs();
            end
            #1;

            // Expected winner: lone requester, or the streak holder until MB consecutive wins
            w = 0; eg0 = 0; eg1 = 0;
            if (bus.m0_req && bus.m1_req) w = (run < MB) ? last : !last;
            else w = bus.m1_req;
            if (bus.m0_req || bus.m1_req) begin eg0 = !w; eg1 = w; end
            total++; if ({bus.m0_gnt, bus.m1_gnt} !== {eg0, eg1}) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {bus.m0_gnt, bus.m1_gnt}, {eg0, eg1}); end

            if (eg0 || eg1) begin
                if (w == last) begin
                    if (run < 15) run++;
                end else begin
                    last = w; run = 1;
                end
                exp_we   = w ? bus.m1_we   : bus.m0_we;
                exp_addr = w ? bus.m1_addr : bus.m0_addr;
                exp_din  = w ? bus.m1_din  : bus.m0_din;
                if (exp_we) begin
                    refmem[exp_addr[7:0]] = exp_din;
                end else begin
                    r.due = c + RL + 2; r.id = w; r.data = refmem[exp_addr[7:0]];
                    q.push_back(r);
                end
            end else begin
                exp_we = 0;
            end
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d exp=0", q.size()); end
    endtask

    initial begin
        rst_n = 1;
        mem_clear = 0;
        test_reset();
        test_single_read();
        test_m1_writes();
        test_contention();
        test_interleaved();
        test_reset_midflight();
        test_latency3();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
